even_parity_serial_tx: RTL and testbench
========================================

Name: even_parity_serial_tx

Overview:
- Transmit-side counterpart to the team's even-parity checker.
- Accepts a parallel data word over a valid/ready handshake and computes its even parity bit.
- Shifts out a serial frame: start bit, data bits LSB first, parity bit, stop bit.
- Sits upstream of the serial link; the far-end receiver recomputes parity and flags Error.

Parameters:
- DATA_W, 4, data word width in bits (≥2).
- CLKS_PER_BIT, 1, clock cycles each serial bit is held on tx_out (≥1).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- in  input  DATA_W  parallel word to send.
- in_valid  input  1  word on `in` is valid.
- in_ready  output  1  block can accept a word this cycle.
- tx_out  output  1  serial line, idle high.
- tx_active  output  1  high while a frame is on the line.
- pb  output  1  parity bit of the word currently being sent (registered at accept).

Behaviour:
- Reset:
  - Synchronous; sampled on rising clk.
  - Next edge gives: state IDLE, tx_out=1, tx_active=0, pb=0, counters=0.
  - in_ready is 0 while rst is high, and 1 on the first cycle after rst falls.
- States: IDLE, START, DATA, PARITY, STOP.
- in_ready = (state==IDLE) && !rst. No acceptance in any other state.
- Accept:
  - A word is accepted on an edge where in_valid && in_ready.
  - At that edge, shift register <= in, and pb <= ^in (even parity: total ones in data+pb is even).
  - State goes to START.
- in_valid held high while busy is ignored; the same word is re-accepted only on a new IDLE cycle.
- Latency: tx_out drives the start bit 0 on the first cycle after the accept edge.
- Bit timing:
  - Each state holds its bit for exactly CLKS_PER_BIT cycles, counted by a baud counter.
  - The baud counter resets to 0 on every state/bit change.
- START: tx_out=0 → DATA.
- DATA:
  - tx_out = shift[0].
  - After each bit period, shift right and increment the bit counter.
  - After DATA_W bits → PARITY.
- PARITY: tx_out=pb → STOP.
- STOP: tx_out=1 → IDLE.
- Frame length: (DATA_W+3)*CLKS_PER_BIT cycles.
- Minimum accept-to-accept spacing: (DATA_W+3)*CLKS_PER_BIT + 1 cycles, because in_ready rises in the cycle after STOP ends.
- tx_active is 1 in START/DATA/PARITY/STOP and 0 in IDLE.
- All outputs except in_ready are registered; no combinational path from `in` to tx_out.
- Reset mid-frame: the frame is aborted. tx_out=1 and tx_active=0 from the next edge; no stop/parity completion; the word is discarded.
- Bit counter wraps cleanly for any DATA_W: counter width is $clog2(DATA_W+1).
- Baud counter width is $clog2(CLKS_PER_BIT+1). With CLKS_PER_BIT=1 it is held at 0 and every state lasts one cycle.

Optional Feature:
- Macro: PARITY_ODD_EN.
- Defined: pb <= ~^in at accept (odd parity; total ones in data+pb is odd). Frame format and timing unchanged.
- Undefined (default): even parity, pb <= ^in.

Test Plan:
- Reset then idle: hold rst=1 for 3 cycles, then release.
  - During reset: tx_out=1, tx_active=0, in_ready=0.
  - Cycle after release: in_ready=1.
- Basic frame, DATA_W=4, CLKS_PER_BIT=1, in=4'b1010 accepted.
  - tx_out on the following 7 cycles: 0,0,1,0,1,0,1.
  - pb=0, tx_active=1 for exactly 7 cycles, then in_ready=1.
- Odd-ones word, in=4'b0001.
  - tx_out = 0,1,0,0,0,1,1; pb=1.
  - With PARITY_ODD_EN defined: parity slot=0 and pb=0.
- Baud stretch, CLKS_PER_BIT=3, in=4'b0000.
  - Each bit held 3 cycles; frame is 21 cycles: 3×0 start, 12×0 data, 3×0 parity, 3×1 stop.
- Handshake hold-off: keep in_valid=1 continuously with in=4'b1111.
  - Accepts exactly once per 8 cycles at CLKS_PER_BIT=1.
  - Parity slot=0 each frame; in_ready low throughout every frame.
- Mid-frame reset and loopback.
  - Assert rst during DATA bit 2: tx_out=1 next cycle, no further frame bits.
  - Loopback check: deserialize frames for all 16 values of in and feed data plus parity bit to the even-parity checker; Error must be 0 for every frame.

Source files
------------

// File: rtl/even_parity_serial_tx_if.sv
// Handshake and serial-line bundle for even_parity_serial_tx.
// The master side supplies words; the slave side (the transmitter) drives the line.
interface even_parity_serial_tx_if #(
    parameter int DATA_W = 4
) ();
    logic [DATA_W-1:0] in;
    logic              in_valid;
    logic              in_ready;
    logic              tx_out;
    logic              tx_active;
    logic              pb;

    modport master (
        output in,
        output in_valid,
        input  in_ready,
        input  tx_out,
        input  tx_active,
        input  pb
    );

    modport slave (
        input  in,
        input  in_valid,
        output in_ready,
        output tx_out,
        output tx_active,
        output pb
    );
endinterface

// File: rtl/even_parity_serial_tx.sv
// Parity serial transmitter: frame = start(0), data LSB first, parity, stop(1).
// Define PARITY_ODD_EN to send odd parity instead of even parity.
module even_parity_serial_tx #(
    parameter int DATA_W       = 4,
    parameter int CLKS_PER_BIT = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    even_parity_serial_tx_if.slave bus
);
    localparam int BIT_W  = $clog2(DATA_W + 1);
    localparam int BAUD_W = $clog2(CLKS_PER_BIT + 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    state_t              state_q,    state_d;
    logic [DATA_W-1:0]   shift_q,    shift_d;
    logic                pb_q,       pb_d;
    logic [BIT_W-1:0]    bit_cnt_q,  bit_cnt_d;
    logic [BAUD_W-1:0]   baud_cnt_q, baud_cnt_d;
    logic                tx_out_q,   tx_out_d;
    logic                tx_active_q, tx_active_d;
    logic                accept_s;
    logic                baud_last_s;

    function automatic logic calc_parity(input logic [DATA_W-1:0] word);
`ifdef PARITY_ODD_EN
        return ~^word;
`else
        return ^word;
`endif
    endfunction

    assign bus.in_ready  = (state_q == S_IDLE) && !rst;
    assign bus.tx_out    = tx_out_q;
    assign bus.tx_active = tx_active_q;
    assign bus.pb        = pb_q;

    assign accept_s    = bus.in_valid && (state_q == S_IDLE);
    assign baud_last_s = (baud_cnt_q == BAUD_W'(CLKS_PER_BIT - 1));

    // Next-state, shift/counter updates and the line value for the next cycle
    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        pb_d       = pb_q;
        bit_cnt_d  = bit_cnt_q;
        baud_cnt_d = baud_cnt_q;

        case (state_q)
            S_IDLE: begin
                if (accept_s) begin
                    shift_d    = bus.in;
                    pb_d       = calc_parity(bus.in);
                    bit_cnt_d  = {BIT_W{1'b0}};
                    baud_cnt_d = {BAUD_W{1'b0}};
                    state_d    = S_START;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_START, S_PARITY, S_STOP: begin
                if (baud_last_s) begin
                    baud_cnt_d = {BAUD_W{1'b0}};
                    if (state_q == S_START) begin
                        state_d = S_DATA;
                    end else if (state_q == S_PARITY) begin
                        state_d = S_STOP;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    baud_cnt_d = baud_cnt_q + BAUD_W'(1);
                end
            end
            S_DATA: begin
                if (baud_last_s) begin
                    baud_cnt_d = {BAUD_W{1'b0}};
                    shift_d    = shift_q >> 1;
                    if (bit_cnt_q == BIT_W'(DATA_W - 1)) begin
                        bit_cnt_d = {BIT_W{1'b0}};
                        state_d   = S_PARITY;
                    end else begin
                        bit_cnt_d = bit_cnt_q + BIT_W'(1);
                    end
                end else begin
                    baud_cnt_d = baud_cnt_q + BAUD_W'(1);
                end
            end
            default: begin
                state_d    = S_IDLE;
                bit_cnt_d  = {BIT_W{1'b0}};
                baud_cnt_d = {BAUD_W{1'b0}};
            end
        endcase

        // The line is registered, so it is derived from where the FSM is going
        case (state_d)
            S_START:  tx_out_d = 1'b0;
            S_DATA:   tx_out_d = shift_d[0];
            S_PARITY: tx_out_d = pb_d;
            default:  tx_out_d = 1'b1;
        endcase
        tx_active_d = (state_d != S_IDLE);
    end

    // State and output registers with synchronous reset aborting any frame
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            shift_q     <= {DATA_W{1'b0}};
            pb_q        <= 1'b0;
            bit_cnt_q   <= {BIT_W{1'b0}};
            baud_cnt_q  <= {BAUD_W{1'b0}};
            tx_out_q    <= 1'b1;
            tx_active_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            shift_q     <= shift_d;
            pb_q        <= pb_d;
            bit_cnt_q   <= bit_cnt_d;
            baud_cnt_q  <= baud_cnt_d;
            tx_out_q    <= tx_out_d;
            tx_active_q <= tx_active_d;
        end
    end
endmodule

// File: tb/tb_even_parity_serial_tx.sv
// Self-checking bench for even_parity_serial_tx: one instance at one clock per bit,
// one at three clocks per bit, checked against a frame-level reference model.
module tb_even_parity_serial_tx;
    logic clk;
    logic rst;
    int   checks;
    int   errors;

`ifdef PARITY_ODD_EN
    localparam logic PAR_ODD = 1'b1;
`else
    localparam logic PAR_ODD = 1'b0;
`endif

    even_parity_serial_tx_if #(.DATA_W(4)) if1 ();
    even_parity_serial_tx_if #(.DATA_W(4)) if3 ();

    even_parity_serial_tx #(.DATA_W(4), .CLKS_PER_BIT(1)) u_dut1 (
        .clk (clk),
        .rst (rst),
        .bus (if1)
    );

    even_parity_serial_tx #(.DATA_W(4), .CLKS_PER_BIT(3)) u_dut3 (
        .clk (clk),
        .rst (rst),
        .bus (if3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] din;
        logic [6:0] exp_bits;   // serial order, index 0 first on the line; even-parity form
        logic       exp_pb;
    } vec_t;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    // Reference model: parity from the ones count, frame assembled slot by slot
    function automatic logic model_parity(input logic [3:0] d);
        return logic'($countones(d) % 2) ^ PAR_ODD;
    endfunction

    function automatic logic [6:0] model_frame(input logic [3:0] d);
        logic [6:0] f;
        f[0] = 1'b0;
        for (int k = 0; k < 4; k++) f[k+1] = d[k];
        f[5] = model_parity(d);
        f[6] = 1'b1;
        return f;
    endfunction

    task automatic wait_ready1(input string nm);
        int w;
        w = 0;
        while (if1.in_ready !== 1'b1 && w < 40) begin
            @(negedge clk);
            w++;
        end
        check({nm, " ready"}, 32'(if1.in_ready), 32'd1);
    endtask

    // Send one word through the 1-clock-per-bit instance and capture its frame
    task automatic capture1(input logic [3:0] d, input string nm,
                            output logic [6:0] bits, output logic pb_seen);
        wait_ready1(nm);
        if1.in       = d;
        if1.in_valid = 1'b1;
        @(negedge clk);
        if1.in_valid = 1'b0;
        pb_seen = if1.pb;
        for (int k = 0; k < 7; k++) begin
            bits[k] = if1.tx_out;
            check($sformatf("%s active[%0d]", nm, k), 32'(if1.tx_active), 32'd1);
            check($sformatf("%s busy ready[%0d]", nm, k), 32'(if1.in_ready), 32'd0);
            @(negedge clk);
        end
        check({nm, " idle active"}, 32'(if1.tx_active), 32'd0);
        check({nm, " idle line"}, 32'(if1.tx_out), 32'd1);
        check({nm, " ready after"}, 32'(if1.in_ready), 32'd1);
    endtask

    // Send one word through the 3-clocks-per-bit instance, compare every cycle to the model
    task automatic frame3(input logic [3:0] d, input string nm);
        logic exp_q[$];
        logic [6:0] f;
        int w;
        f = model_frame(d);
        exp_q = {};
        for (int s = 0; s < 7; s++) for (int c = 0; c < 3; c++) exp_q.push_back(f[s]);
        w = 0;
        while (if3.in_ready !== 1'b1 && w < 80) begin
            @(negedge clk);
            w++;
        end
        check({nm, " ready"}, 32'(if3.in_ready), 32'd1);
        if3.in       = d;
        if3.in_valid = 1'b1;
        @(negedge clk);
        if3.in_valid = 1'b0;
        check({nm, " pb"}, 32'(if3.pb), 32'(model_parity(d)));
        for (int i = 0; i < exp_q.size(); i++) begin
            check($sformatf("%s line[%0d]", nm, i), 32'(if3.tx_out), 32'(exp_q[i]));
            check($sformatf("%s active[%0d]", nm, i), 32'(if3.tx_active), 32'd1);
            @(negedge clk);
        end
        check({nm, " end active"}, 32'(if3.tx_active), 32'd0);
        check({nm, " end line"}, 32'(if3.tx_out), 32'd1);
        check({nm, " end ready"}, 32'(if3.in_ready), 32'd1);
    endtask

    initial begin
        vec_t       vecs [4];
        logic [6:0] bits;
        logic [6:0] hold_f;
        logic       pb_seen;
        int         accepts;
        logic [3:0] rx_data;
        logic       rx_par;
        int         gap;

        checks = 0;
        errors = 0;

        vecs[0] = '{din: 4'b1010, exp_bits: 7'b1010100, exp_pb: 1'b0};
        vecs[1] = '{din: 4'b0001, exp_bits: 7'b1100010, exp_pb: 1'b1};
        vecs[2] = '{din: 4'b1111, exp_bits: 7'b1011110, exp_pb: 1'b0};
        vecs[3] = '{din: 4'b0111, exp_bits: 7'b1101110, exp_pb: 1'b1};

        if1.in = 4'd0; if1.in_valid = 1'b0;
        if3.in = 4'd0; if3.in_valid = 1'b0;
        rst = 1'b1;

        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check($sformatf("reset line[%0d]", c), 32'(if1.tx_out), 32'd1);
            check($sformatf("reset active[%0d]", c), 32'(if1.tx_active), 32'd0);
            check($sformatf("reset ready[%0d]", c), 32'(if1.in_ready), 32'd0);
            check($sformatf("reset pb[%0d]", c), 32'(if1.pb), 32'd0);
            check($sformatf("reset3 line[%0d]", c), 32'(if3.tx_out), 32'd1);
            check($sformatf("reset3 ready[%0d]", c), 32'(if3.in_ready), 32'd0);
        end
        rst = 1'b0;
        @(negedge clk);
        check("release ready", 32'(if1.in_ready), 32'd1);
        check("release ready3", 32'(if3.in_ready), 32'd1);

        // Table-driven frames; parity slot and pb flip when odd parity is built in
        for (int v = 0; v < 4; v++) begin
            capture1(vecs[v].din, $sformatf("vec%0d", v), bits, pb_seen);
            check($sformatf("vec%0d frame", v), 32'(bits),
                  32'(vecs[v].exp_bits ^ {1'b0, PAR_ODD, 5'b00000}));
            check($sformatf("vec%0d pb", v), 32'(pb_seen), 32'(vecs[v].exp_pb ^ PAR_ODD));
        end

        // Baud stretch, then randomized words with random idle gaps
        frame3(4'b0000, "stretch");
        for (int r = 0; r < 12; r++) begin
            gap = int'($urandom_range(0, 3));
            repeat (gap) begin
                @(negedge clk);
                check($sformatf("gap%0d line", r), 32'(if3.tx_out), 32'd1);
            end
            frame3(4'($urandom), $sformatf("rand%0d", r));
        end

        // Continuous in_valid: one accept every 8 cycles
        wait_ready1("hold");
        hold_f = model_frame(4'b1111);
        accepts = 0;
        if1.in = 4'b1111;
        if1.in_valid = 1'b1;
        for (int c = 0; c < 24; c++) begin
            if (if1.in_ready === 1'b1) accepts++;
            check($sformatf("hold ready[%0d]", c), 32'(if1.in_ready), 32'((c % 8) == 0));
            if ((c % 8) == 0) begin
                check($sformatf("hold line[%0d]", c), 32'(if1.tx_out), 32'd1);
            end else begin
                check($sformatf("hold line[%0d]", c), 32'(if1.tx_out), 32'(hold_f[(c % 8) - 1]));
            end
            @(negedge clk);
        end
        if1.in_valid = 1'b0;
        check("hold accepts", 32'(accepts), 32'd3);

        // Reset while data bit 2 is on the line
        repeat (8) @(negedge clk);
        wait_ready1("abort");
        if1.in = 4'b0110;
        if1.in_valid = 1'b1;
        @(negedge clk);
        if1.in_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("abort bit2 line", 32'(if1.tx_out), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        check("abort line", 32'(if1.tx_out), 32'd1);
        check("abort active", 32'(if1.tx_active), 32'd0);
        check("abort ready", 32'(if1.in_ready), 32'd0);
        check("abort pb", 32'(if1.pb), 32'd0);
        rst = 1'b0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            check($sformatf("abort quiet line[%0d]", c), 32'(if1.tx_out), 32'd1);
            check($sformatf("abort quiet active[%0d]", c), 32'(if1.tx_active), 32'd0);
        end

        // Loopback: deserialize every word and run the far-end parity check
        for (int v = 0; v < 16; v++) begin
            capture1(4'(v), $sformatf("loop%0d", v), bits, pb_seen);
            rx_data = bits[4:1];
            rx_par  = bits[5];
            check($sformatf("loop%0d start", v), 32'(bits[0]), 32'd0);
            check($sformatf("loop%0d stop", v), 32'(bits[6]), 32'd1);
            check($sformatf("loop%0d data", v), 32'(rx_data), 32'(v));
            check($sformatf("loop%0d parity error", v), 32'(^{rx_data, rx_par}), 32'(PAR_ODD));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
